mac_job_sequencer: RTL and testbench

//  Sequences the 8x8->16 MAC datapath (mac_top) through dot-product jobs of programmable length.
//  Per job: clears the accumulator, streams LEN operand pairs from a valid/ready source into the MAC,

---
 rtl/mac_job_sequencer_if.sv | 43 ++++
 rtl/mac_job_sequencer.sv | 124 ++++++++++++
 tb/tb_mac_job_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_job_sequencer_if.sv
// Handshake bundle between the operand producer, the result consumer, mac_top
// and the job sequencer.
interface mac_job_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              mac_enable;
    logic              mac_clear;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_result;
    logic              mac_overflow;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_result;
    logic              out_overflow;

    // Sequencer side.
    modport slave (
        input  start, len, abort, in_valid, in_a, in_b, mac_result, mac_overflow, out_ready,
        output busy, in_ready, mac_enable, mac_clear, mac_a, mac_b, out_valid, out_result,
        output out_overflow
    );

    // Environment side: producer, consumer and mac_top.
    modport master (
        output start, len, abort, in_valid, in_a, in_b, mac_result, mac_overflow, out_ready,
        input  busy, in_ready, mac_enable, mac_clear, mac_a, mac_b, out_valid, out_result,
        input  out_overflow
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// Runs dot-product jobs of programmable length through mac_top: clear, stream operands,
// drain the MAC pipeline, then hold result and sticky overflow until the consumer takes it.
module mac_job_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    mac_job_sequencer_if.slave bus
);
    localparam int unsigned DrainW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StOutput} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DrainW-1:0]  drain_q, drain_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_ovf_q, res_ovf_d;

    logic in_ready;
    logic xfer;
    logic abort_act;
    logic drain_done;

    // Abort and reset both withdraw in_ready so an offered pair is never half-accepted.
    assign in_ready   = (state_q == StAccum) && !bus.abort && !rst;
    assign xfer       = in_ready && bus.in_valid;
    assign abort_act  = bus.abort &&
                        (state_q == StClear || state_q == StAccum || state_q == StDrain);
    assign drain_done = (state_q == StDrain) && (drain_q == DrainW'(MAC_LAT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        drain_d   = drain_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        if (abort_act) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            len_d   = bus.len;
                            cnt_d   = '0;
                            state_d = StClear;
                        end else begin
                            res_d     = '0;
                            res_ovf_d = 1'b0;
                            state_d   = StOutput;
                        end
                    end
                end
                StClear: begin
                    ovf_d   = 1'b0;
                    drain_d = '0;
                    state_d = StAccum;
                end
                StAccum: begin
                    ovf_d = ovf_q | bus.mac_overflow;
                    if (xfer) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    ovf_d   = ovf_q | bus.mac_overflow;
                    drain_d = drain_q + DrainW'(1);
                    if (drain_done) begin
                        res_d     = bus.mac_result;
                        res_ovf_d = ovf_q | bus.mac_overflow;
                        state_d   = StOutput;
                    end
                end
                StOutput: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            drain_q   <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            drain_q   <= drain_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign bus.busy         = (state_q != StIdle) && !rst;
    assign bus.in_ready     = in_ready;
    assign bus.mac_enable   = xfer;
    assign bus.mac_clear    = rst || (state_q == StClear) || abort_act;
    assign bus.mac_a        = bus.in_a[DATA_W-1:0];
    assign bus.mac_b        = bus.in_b[DATA_W-1:0];
    assign bus.out_valid    = (state_q == StOutput) && !rst;
    assign bus.out_result   = res_q;
    assign bus.out_overflow = res_ovf_q;
endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural 8x8->16 MAC model behind it.
module tb_mac_job_sequencer;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAC_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_job_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    mac_job_sequencer #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // MAC model: overflow flags only the most recent term, so any stickiness is the DUT's.
    logic [15:0] acc;
    logic        acc_ovf;
    logic [16:0] sum;
    always_comb sum = {1'b0, acc} + {1'b0, 16'(bus.mac_a) * 16'(bus.mac_b)};
    always @(posedge clk) begin
        if (bus.mac_clear) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (bus.mac_enable) begin
            acc     <= sum[15:0];
            acc_ovf <= sum[16];
        end
    end
    assign bus.mac_result   = acc;
    assign bus.mac_overflow = acc_ovf;

    int en_total = 0;
    int hs_total = 0;
    int ov_total = 0;
    always @(posedge clk) begin
        if (bus.mac_enable) en_total <= en_total + 1;
        if (bus.out_valid && bus.out_ready) hs_total <= hs_total + 1;
        if (bus.out_valid) ov_total <= ov_total + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [7:0]      len;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic            gap;
        logic [3:0]      hold;
        logic [15:0]     exp_res;
        logic            exp_ovf;
        logic [7:0]      exp_en;
    } vec_t;

    vec_t vecs[9];

    task automatic set_vec(input int i, input int l, input logic [31:0] a, input logic [31:0] b,
                           input bit gap, input int hold, input int res, input bit ovf,
                           input int en);
        vecs[i].len     = 8'(l);
        vecs[i].a       = a;
        vecs[i].b       = b;
        vecs[i].gap     = gap;
        vecs[i].hold    = 4'(hold);
        vecs[i].exp_res = 16'(res);
        vecs[i].exp_ovf = ovf;
        vecs[i].exp_en  = 8'(en);
    endtask

    task automatic run_job(input vec_t v);
        int e0;
        int h0;
        int idx;
        int guard;
        e0 = en_total;
        h0 = hs_total;
        idx = 0;
        guard = 0;
        step();
        bus.start = 1'b1;
        bus.len   = v.len;
        #1;
        check("idle_not_busy", bus.busy, 1'b0);
        step();
        bus.start = 1'b0;
        bus.len   = 8'hff;
        #1;
        if (v.len != 0) begin
            check("clear_pulse", bus.mac_clear, 1'b1);
            check("clear_no_ready", bus.in_ready, 1'b0);
            while (idx < int'(v.len) && guard < 40) begin
                step();
                guard++;
                if (v.gap && (guard % 2 == 1)) begin
                    bus.in_valid = 1'b0;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_a     = v.a[idx];
                    bus.in_b     = v.b[idx];
                end
                #1;
                if (bus.in_valid && bus.in_ready) begin
                    check("accum_no_clear", bus.mac_clear, 1'b0);
                    idx++;
                end
            end
            check("feed_count", idx, v.len);
            step();
            bus.in_valid = 1'b0;
            #1;
            check("drain_no_ready", bus.in_ready, 1'b0);
        end
        for (int i = 0; i < 10 && !bus.out_valid; i++) begin
            step();
            #1;
        end
        check("out_valid_seen", bus.out_valid, 1'b1);
        for (int h = 0; h < int'(v.hold); h++) begin
            bus.start = 1'b1;
            bus.abort = 1'b1;
            bus.len   = 8'd3;
            check("hold_result", bus.out_result, v.exp_res);
            check("hold_no_ready", bus.in_ready, 1'b0);
            step();
            #1;
            check("hold_valid", bus.out_valid, 1'b1);
        end
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("out_result", bus.out_result, v.exp_res);
        check("out_overflow", bus.out_overflow, v.exp_ovf);
        step();
        bus.out_ready = 1'b0;
        #1;
        check("valid_drop", bus.out_valid, 1'b0);
        repeat (2) step();
        #1;
        check("enable_pulses", en_total - e0, v.exp_en);
        check("one_result", hs_total - h0, 1);
    endtask

    // Start a job, transfer n pairs, then offer pair n+1 together with abort.
    task automatic abort_job(input int l, input int n);
        int e0;
        int o0;
        e0 = en_total;
        o0 = ov_total;
        step();
        bus.start = 1'b1;
        bus.len   = 8'(l);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(i + 1);
            bus.in_b     = 8'(i + 1);
        end
        step();
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        #1;
        check("abort_no_ready", bus.in_ready, 1'b0);
        check("abort_no_enable", bus.mac_enable, 1'b0);
        check("abort_clear", bus.mac_clear, 1'b1);
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("abort_idle", bus.busy, 1'b0);
        repeat (5) step();
        check("abort_no_output", ov_total - o0, 0);
        check("abort_enables", en_total - e0, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int o0;
        set_vec(0, 3, {8'd0, 8'd10, 8'd2, 8'd5}, {8'd0, 8'd10, 8'd4, 8'd3}, 0, 0, 123, 0, 3);
        set_vec(1, 3, {8'd0, 8'd10, 8'd2, 8'd5}, {8'd0, 8'd10, 8'd4, 8'd3}, 1, 0, 123, 0, 3);
        set_vec(2, 2, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd255, 8'd255}, 0, 0, 64514,
                1, 2);
        set_vec(3, 1, {8'd0, 8'd0, 8'd0, 8'd15}, {8'd0, 8'd0, 8'd0, 8'd2}, 0, 0, 30, 0, 1);
        set_vec(4, 0, 32'd0, 32'd0, 0, 2, 0, 0, 0);
        set_vec(5, 1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd7}, 0, 5, 49, 0, 1);
        set_vec(6, 4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 1, 2, 30, 0, 4);
        set_vec(7, 2, {8'd0, 8'd0, 8'd1, 8'd255}, {8'd0, 8'd0, 8'd1, 8'd255}, 0, 0, 65026, 0, 2);
        set_vec(8, 3, {8'd0, 8'd1, 8'd255, 8'd255}, {8'd0, 8'd1, 8'd255, 8'd255}, 0, 0, 64515,
                1, 3);

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        step();
        check("rst_mac_clear", bus.mac_clear, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_mac_enable", bus.mac_enable, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_result", bus.out_result, 16'd0);
        check("rst_out_overflow", bus.out_overflow, 1'b0);
        check("idle_no_clear", bus.mac_clear, 1'b0);

        for (int i = 0; i < 9; i++) run_job(vecs[i]);

        abort_job(4, 2);
        abort_job(2, 1);
        abort_job(1, 0);
        run_job(vecs[5]);

        // Reset in the middle of ACCUM after one accepted pair.
        o0 = ov_total;
        step();
        bus.start = 1'b1;
        bus.len   = 8'd3;
        step();
        bus.start = 1'b0;
        step();
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd9;
        bus.in_b     = 8'd9;
        step();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_mac_enable", bus.mac_enable, 1'b0);
        check("midrst_mac_clear", bus.mac_clear, 1'b1);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_result", bus.out_result, 16'd0);
        check("midrst_out_overflow", bus.out_overflow, 1'b0);
        check("midrst_idle", bus.busy, 1'b0);
        repeat (5) step();
        check("midrst_no_output", ov_total - o0, 0);

        run_job(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
